// File: rtl/or16.sv
// or16: 16-bit word OR built from nand2tetris-style Or cells (two inverters + NAND per bit), plus a registered copy.
// Latency: out is combinational (0 cycles); out_q lags a/b by one rising clk edge.
// Backpressure: none; new operands are accepted every cycle and nothing can stall the block.
module or16 #(
    parameter int WIDTH = 16
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out_q
);

    logic [WIDTH-1:0] w_not_a;
    logic [WIDTH-1:0] w_not_b;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] r_out_q;

    // One independent cell per bit: or(x,y) = nand(not x, not y); no cross-bit logic.
    for (genvar i = 0; i < WIDTH; i++) begin : g_or_cell
        assign w_not_a[i] = ~a[i];
        assign w_not_b[i] = ~b[i];
        assign w_or[i]    = ~(w_not_a[i] & w_not_b[i]);
    end

    // The combinational result never touches clk or reset.
    assign out = w_or;

    // Registered copy; reset clears it immediately, without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_q <= '0;
        end else begin
            r_out_q <= w_or;
        end
    end

    assign out_q = r_out_q;

endmodule

// File: tb/tb_or16.sv
// tb_or16: self-checking bench for or16 (combinational and registered paths).
// Latency: checks out immediately and out_q one rising edge after operands change.
// Backpressure: none in the design; the bench drives new operands every cycle.
module tb_or16;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] a     = 16'h0000;
    logic [15:0] b     = 16'h0000;
    logic [15:0] out;
    logic [15:0] out_q;

    int n_checks = 0;
    int n_pass   = 0;

    or16 dut (
        .out   (out),
        .a     (a),
        .b     (b),
        .clk   (clk),
        .reset (reset),
        .out_q (out_q)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference OR from plain arithmetic: x + y counts shared ones twice, so subtract them once.
    function automatic logic [15:0] ref_or(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] sum;
        sum = {1'b0, x} + {1'b0, y} - {1'b0, x & y};
        return sum[15:0];
    endfunction

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (out_q !== 16'h0000) $display("FAIL reset_out_q actual=%h required=0000", out_q);
        else n_pass++;
        n_checks++;
        if (out !== 16'h0000) $display("FAIL zero_operands actual=%h required=0000", out);
        else n_pass++;
    endtask

    task automatic test_truth_table();
        logic [1:0] tt [4];
        logic [15:0] exp;
        tt[0] = 2'b10; tt[1] = 2'b01; tt[2] = 2'b11; tt[3] = 2'b00;
        for (int k = 0; k < 4; k++) begin
            a = {15'h0, tt[k][1]};
            b = {15'h0, tt[k][0]};
            exp = (tt[k] != 2'b00) ? 16'h0001 : 16'h0000;
            #1;
            n_checks++;
            if (out !== exp) $display("FAIL truth_table a=%h b=%h actual=%h required=%h", a, b, out, exp);
            else n_pass++;
            #9;
        end
    endtask

    task automatic test_full_word();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [15:0] ve [4];
        va[0] = 16'hAAAA; vb[0] = 16'h5555; ve[0] = 16'hFFFF;
        va[1] = 16'h8001; vb[1] = 16'h0000; ve[1] = 16'h8001;
        va[2] = 16'hFFFF; vb[2] = 16'h1234; ve[2] = 16'hFFFF;
        va[3] = 16'h0000; vb[3] = 16'hC3C3; ve[3] = 16'hC3C3;
        for (int k = 0; k < 4; k++) begin
            a = va[k];
            b = vb[k];
            #1;
            n_checks++;
            if (out !== ve[k]) $display("FAIL full_word a=%h b=%h actual=%h required=%h", a, b, out, ve[k]);
            else n_pass++;
        end
    endtask

    task automatic test_walking();
        logic [15:0] one;
        for (int i = 0; i < 16; i++) begin
            one = 16'h0001 << i;
            a = one; b = 16'h0000;
            #1;
            n_checks++;
            if (out !== one) $display("FAIL walk_a bit=%0d actual=%h required=%h", i, out, one);
            else n_pass++;
            a = 16'h0000; b = one;
            #1;
            n_checks++;
            if (out !== one) $display("FAIL walk_b bit=%0d actual=%h required=%h", i, out, one);
            else n_pass++;
        end
    endtask

    task automatic test_comb_random();
        logic [15:0] exp;
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            exp = ref_or(a, b);
            #1;
            n_checks++;
            if (out !== exp) $display("FAIL comb_random a=%h b=%h actual=%h required=%h", a, b, out, exp);
            else n_pass++;
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        reset = 1'b0;
        a = 16'h0F0F;
        b = 16'hF000;
        #1;
        n_checks++;
        if (out !== 16'hFF0F) $display("FAIL reg_out_before_edge actual=%h required=ff0f", out);
        else n_pass++;
        n_checks++;
        if (out_q !== 16'h0000) $display("FAIL reg_q_before_edge actual=%h required=0000", out_q);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_q !== 16'hFF0F) $display("FAIL reg_q_after_edge actual=%h required=ff0f", out_q);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'h0000;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_q !== 16'hFFFF) $display("FAIL mid_preload actual=%h required=ffff", out_q);
        else n_pass++;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (out_q !== 16'h0000) $display("FAIL mid_reset_q actual=%h required=0000", out_q);
        else n_pass++;
        n_checks++;
        if (out !== 16'hFFFF) $display("FAIL mid_reset_out actual=%h required=ffff", out);
        else n_pass++;
    endtask

    task automatic test_reset_hold();
        logic [15:0] exp;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom) | 16'h0100;
            exp = ref_or(a, b);
            @(posedge clk);
            #1;
            n_checks++;
            if (out_q !== 16'h0000) $display("FAIL hold_reset_q actual=%h required=0000", out_q);
            else n_pass++;
            n_checks++;
            if (out !== exp) $display("FAIL hold_reset_out actual=%h required=%h", out, exp);
            else n_pass++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q;
        logic [15:0] exp;
        exp_q = ref_or(a, b);
        @(posedge clk);
        #1;
        n_checks++;
        if (out_q !== exp_q) $display("FAIL b2b_first actual=%h required=%h", out_q, exp_q);
        else n_pass++;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_q !== exp_q) $display("FAIL b2b_hold cycle=%0d actual=%h required=%h", k, out_q, exp_q);
            else n_pass++;
            a = 16'($urandom);
            b = 16'($urandom);
            exp = ref_or(a, b);
            if ($urandom_range(0, 9) == 0) begin
                #1 reset = 1'b1;
                #1;
                n_checks++;
                if (out_q !== 16'h0000) $display("FAIL b2b_reset cycle=%0d actual=%h required=0000", k, out_q);
                else n_pass++;
                #1 reset = 1'b0;
            end
            exp_q = exp;
            @(posedge clk);
            #1;
            n_checks++;
            if (out_q !== exp_q) $display("FAIL b2b_q cycle=%0d a=%h b=%h actual=%h required=%h", k, a, b, out_q, exp_q);
            else n_pass++;
            n_checks++;
            if (out !== exp) $display("FAIL b2b_out cycle=%0d actual=%h required=%h", k, out, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_full_word();
        test_walking();
        test_comb_random();
        test_registered();
        test_reset_mid();
        test_reset_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
